// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nes_mem_arbiter
// Brief    : Two-master Avalon-MM arbiter for the shared 8192x32 program/data
//            RAM. Master 0 is the 6502 data port, master 1 the PPU/OAM-DMA
//            engine. Bounded-run round-robin grant, one-cycle read latency
//            routed back to the issuing master by a tag.
// Revision : 1.0 - initial release
// ============================================================================
module nes_mem_arbiter #(
  parameter int MAX_RUN = 4,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  // master 0 : 6502 data port
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  // master 1 : PPU / OAM-DMA fetch engine
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  // RAM slave
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  localparam logic [3:0] c_max_run = MAX_RUN[3:0];
  localparam logic [3:0] c_run_sat = 4'hF;

  // arbitration state
  logic       r_last_owner;
  logic [3:0] r_run_cnt;
  // outstanding read response
  logic       r_rd_pend;
  logic       r_rd_tag;

  logic w_m0_req;
  logic w_m1_req;
  logic w_grant;
  logic w_winner;
  logic w_win_read;
  logic w_win_write;
  logic w_rd_issue;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

  // Grant decision: the owner keeps the bus under contention until it has
  // used up its run; reset suppresses every grant.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = 1'b0;
    if (!reset) begin
      if (w_m0_req && w_m1_req) begin
        w_grant  = 1'b1;
        w_winner = (r_run_cnt < c_max_run) ? r_last_owner : ~r_last_owner;
      end else if (w_m0_req) begin
        w_grant  = 1'b1;
        w_winner = 1'b0;
      end else if (w_m1_req) begin
        w_grant  = 1'b1;
        w_winner = 1'b1;
      end
    end
  end

  // Request mux toward the RAM; with no grant the select stays on master 0.
  always_comb begin
    w_win_read     = w_winner ? m1_read       : m0_read;
    w_win_write    = w_winner ? m1_write      : m0_write;
    mem_address    = w_winner ? m1_address    : m0_address;
    mem_byteenable = w_winner ? m1_byteenable : m0_byteenable;
    mem_writedata  = w_winner ? m1_writedata  : m0_writedata;
  end

  // A read+write request is treated as a write, so it never expects data.
  assign w_rd_issue     = w_grant & w_win_read & ~w_win_write;
  assign mem_chipselect = w_grant;
  assign mem_write      = w_grant & w_win_write;
  assign m0_waitrequest = ~(w_grant & ~w_winner);
  assign m1_waitrequest = ~(w_grant &  w_winner);

  // Read data is shared; only the valid strobe is steered by the tag. A
  // response that lands while reset is high is dropped.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rd_pend & ~r_rd_tag & ~reset;
  assign m1_readdatavalid = r_rd_pend &  r_rd_tag & ~reset;

  // Run counter / owner tracking and read-response tagging.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= 1'b0;
      r_run_cnt    <= 4'd0;
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= 1'b0;
    end else begin
      if (w_grant) begin
        if (w_winner == r_last_owner) begin
          if (r_run_cnt != c_run_sat) begin
            r_run_cnt <= r_run_cnt + 4'd1;
          end
        end else begin
          r_last_owner <= w_winner;
          r_run_cnt    <= 4'd1;
        end
      end else begin
        r_run_cnt <= 4'd0;
      end
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_tag <= w_winner;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_mem_arbiter
// Brief    : Vector-table bench for nes_mem_arbiter with a behavioural RAM,
//            a shadow memory for expected data and a response queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [31:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  nes_mem_arbiter #(.MAX_RUN(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 ^ (i * 32'h0001_0101);
    if (i == 16) w = 32'hDEAD_BEEF;
    return w;
  endfunction

  // Behavioural single-port RAM, one-cycle read latency.
  logic [31:0] ram [DEPTH];
  logic        tb_init;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  typedef struct {
    bit rst;
    bit r0, w0; logic [ADDR_W-1:0] a0; logic [31:0] d0; logic [3:0] be0;
    bit r1, w1; logic [ADDR_W-1:0] a1; logic [31:0] d1; logic [3:0] be1;
    bit ew0, ew1, ecs, ewe;
  } vec_t;

  typedef struct {
    bit          tag;
    logic [31:0] data;
  } resp_t;

  logic [31:0] exp_mem [DEPTH];
  resp_t       sb [$];
  vec_t        vecs [$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(
    input bit rst,
    input bit r0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [31:0] d0, input logic [3:0] be0,
    input bit r1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [31:0] d1, input logic [3:0] be1,
    input bit ew0, input bit ew1, input bit ecs, input bit ewe);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
    v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe;
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mk(0, 0,0,'0,'0,4'h0, 0,0,'0,'0,4'h0, 1,1,0,0);
  endfunction

  // both masters reading; m1_wins selects the expected grant
  function automatic vec_t both_rd(input bit rst, input bit m1_wins);
    if (rst) return mk(1, 1,0,13'h100,'0,4'hF, 1,0,13'h200,'0,4'hF, 1,1,0,0);
    return mk(0, 1,0,13'h100,'0,4'hF, 1,0,13'h200,'0,4'hF, m1_wins, ~m1_wins, 1, 0);
  endfunction

  function automatic vec_t m0_rd(input logic [ADDR_W-1:0] a);
    return mk(0, 1,0,a,'0,4'hF, 0,0,'0,'0,4'h0, 0,1,1,0);
  endfunction

  function automatic vec_t m1_rd(input logic [ADDR_W-1:0] a);
    return mk(0, 0,0,'0,'0,4'h0, 1,0,a,'0,4'hF, 1,0,1,0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check last cycle's response, check grant, predict.
  task automatic step(input vec_t v);
    resp_t             e;
    bit                have;
    bit                win;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd;
    logic [3:0]        be;
    reset = v.rst;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
    #1;
    have = 1'b0;
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      have = !v.rst;
    end
    if (have) begin
      chk("rdvalid_owner", {30'd0, m1_readdatavalid, m0_readdatavalid}, e.tag ? 32'd2 : 32'd1);
      chk("readdata", e.tag ? m1_readdata : m0_readdata, e.data);
    end else begin
      chk("rdvalid_none", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    end
    chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, v.ew0});
    chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, v.ew1});
    chk("mem_chipselect", {31'd0, mem_chipselect}, {31'd0, v.ecs});
    chk("mem_write",      {31'd0, mem_write},      {31'd0, v.ewe});
    if (v.ecs) begin
      win = v.ew0;
      a   = win ? v.a1  : v.a0;
      wd  = win ? v.d1  : v.d0;
      be  = win ? v.be1 : v.be0;
      chk("mem_address", {19'd0, mem_address}, {19'd0, a});
      chk("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, be});
      if (v.ewe) begin
        chk("mem_writedata", mem_writedata, wd);
        for (int b = 0; b < 4; b++)
          if (be[b]) exp_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        sb.push_back('{tag: win, data: exp_mem[a]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table ----
    vecs.push_back(both_rd(1, 0));                   // reset, both reading
    vecs.push_back(both_rd(1, 0));
    vecs.push_back(m0_rd(13'h0010));                 // solo read DEADBEEF
    vecs.push_back(idle_v());
    vecs.push_back(mk(0, 0,0,'0,'0,4'h0, 0,1,13'h1FFF,32'h0000_00AB,4'b0001, 1,0,1,1)); // byte write
    vecs.push_back(m0_rd(13'h1FFF));
    vecs.push_back(idle_v());
    vecs.push_back(both_rd(1, 0));                   // contention from reset
    for (int i = 0; i < 12; i++) vecs.push_back(both_rd(0, (i >= 4) && (i < 8)));
    vecs.push_back(idle_v());
    vecs.push_back(m1_rd(13'h0040));                 // m1 owns 2 grants
    vecs.push_back(m1_rd(13'h0041));
    vecs.push_back(idle_v());                        // gap clears run
    for (int i = 0; i < 5; i++) vecs.push_back(both_rd(0, i < 4));
    vecs.push_back(idle_v());
    vecs.push_back(m0_rd(13'h0010));                 // read then write
    vecs.push_back(mk(0, 0,0,'0,'0,4'h0, 0,1,13'h0020,32'h1234_5678,4'hF, 1,0,1,1));
    vecs.push_back(idle_v());
    vecs.push_back(m0_rd(13'h0020));
    vecs.push_back(idle_v());
    vecs.push_back(mk(0, 1,1,13'h0030,32'hCAFE_F00D,4'hF, 0,0,'0,'0,4'h0, 0,1,1,1)); // rd+wr
    vecs.push_back(idle_v());
    vecs.push_back(m0_rd(13'h0030));
    vecs.push_back(idle_v());
    vecs.push_back(m0_rd(13'h0010));                 // read then reset
    vecs.push_back(mk(1, 0,0,'0,'0,4'h0, 0,0,'0,'0,4'h0, 1,1,0,0));
    vecs.push_back(idle_v());
    vecs.push_back(idle_v());

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    tb_init = 1'b1;
    @(posedge clk);
    #1;
    tb_init = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nes_mem_arbiter.md
# nes_mem_arbiter

Two-master arbiter that shares the single-port 8192×32 on-chip program/data RAM between the 6502 core data port (master 0) and the PPU/OAM-DMA fetch engine (master 1). It sits between both Avalon-MM masters and the RAM slave. It serialises their transfers with bounded-run round-robin priority and routes the fixed one-cycle read latency back to the issuing master.

## Interface
Parameters:
- `MAX_RUN`, default 4: maximum consecutive grants to one master while the other is waiting. Legal range 1–15.
- `ADDR_W`, default 13: word-address width, matching the 8192-word RAM.

Ports (clock and reset first):
- `clk`  in  1: single clock for the block and the RAM.
- `reset`  in  1: synchronous, active-high reset.
- `m0_address` / `m1_address`  in  ADDR_W: word address.
- `m0_byteenable` / `m1_byteenable`  in  4: byte lanes.
- `m0_read` / `m1_read`  in  1: read request.
- `m0_write` / `m1_write`  in  1: write request.
- `m0_writedata` / `m1_writedata`  in  32: write data.
- `m0_waitrequest` / `m1_waitrequest`  out  1: request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  32: read data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1: readdata valid.
- `mem_address`  out  ADDR_W: RAM address.
- `mem_byteenable`  out  4: RAM byte enables.
- `mem_chipselect`  out  1: RAM select.
- `mem_write`  out  1: RAM write.
- `mem_writedata`  out  32: RAM write data.
- `mem_readdata`  in  32: RAM read data, valid one cycle after address.

## Operation
- Request: `mX_req = mX_read | mX_write`. If a master asserts both in the same cycle, the transfer is a write and no read response is returned.
- Grant is combinational each cycle. Exactly one or zero masters are granted.
  - Only one master requesting: that master wins.
  - Both requesting: the last owner wins if `run_cnt < MAX_RUN`; otherwise the other master wins.
  - Neither requesting: no grant.
- State registers:
  - `last_owner`: 1 bit, reset 0.
  - `run_cnt`: 4 bits, reset 0.
  - `rd_pend`: 1 bit, reset 0.
  - `rd_tag`: 1 bit, reset 0.
- Register updates on a grant:
  - Winner equals `last_owner`: `run_cnt` increments, saturating at 15.
  - Otherwise: `last_owner` ← winner and `run_cnt` ← 1.
- Register updates on a cycle with no grant: `run_cnt` ← 0 and `last_owner` is held.
- Granted master sees:
  - `mX_waitrequest` = 0.
  - `mem_chipselect` = 1.
  - `mem_address`, `mem_byteenable` and `mem_writedata` taken from the winner.
  - `mem_write` = the winner's write.
- Ungranted requesting master sees `mX_waitrequest` = 1 and must hold all its signals stable (Avalon rule).
- Master not requesting: `mX_waitrequest` = 1.
- Read response:
  - A granted read sets `rd_pend` ← 1 and `rd_tag` ← winner.
  - Any other cycle sets `rd_pend` ← 0.
  - `m{rd_tag}_readdatavalid` = `rd_pend`.
  - Both `mX_readdata` = `mem_readdata`, unregistered pass-through.
- Reads may be issued back-to-back, one per cycle. A write may immediately follow a read: its response is still delivered to the earlier read's owner via `rd_tag`.
- No grant: `mem_chipselect` = 0 and `mem_write` = 0. Address and data mux select master 0 (don't-care to the RAM).

## Timing
- Grant latency: 0 cycles. Accept happens in the same cycle as the request if the master wins.
- Read latency: `mX_readdatavalid` is high exactly 1 cycle after acceptance.
- Write completes on the accept edge.
- Worst-case wait for a requesting master while the other requests continuously: `MAX_RUN` cycles.
- Reset behaviour:
  - While `reset` is high, all grants are suppressed: both waitrequest = 1, `mem_chipselect` = 0, `mem_write` = 0.
  - All state registers clear on the first clocked edge with `reset` high.
  - On the cycle after a reset edge: `mX_readdatavalid` = 0.
- A read accepted in the cycle before reset asserts returns no valid response; the master must reissue.
- `MAX_RUN` = 1 gives strict alternation under contention.

## Test plan
- **Reset:** assert `reset` for 2 cycles with both masters reading → both waitrequest = 1, `mem_chipselect` = 0, `readdatavalid` = 0 throughout and on the following cycle.
- **Solo read:** m0 reads addr 0x0010 with RAM word 0xDEADBEEF → waitrequest 0 at cycle N; `m0_readdatavalid` = 1 and readdata 0xDEADBEEF at N+1; `m1_readdatavalid` stays 0.
- **Byte write:** m1 writes 0x000000AB to addr 0x1FFF with byteenable 0001; m0 then reads 0x1FFF → low byte 0xAB, other bytes unchanged.
- **Contention:** `MAX_RUN` = 4, both masters read continuously from reset → grant sequence m0 ×4, m1 ×4, m0 ×4. Each readdatavalid is tagged to the correct master; no lost or duplicated responses.
- **Idle gap:** m1 owns 2 grants, then one idle cycle, then both request → `run_cnt` has cleared to 0, so m1 (`last_owner`) wins 4 more grants.
- **Read then write / read and write together:** m0 read at N and m1 write at N+1 → `m0_readdatavalid` at N+1 only. Separately, m0 asserts read and write together → treated as a write, with no readdatavalid.
